dbg_run_control: RTL and testbench

DBG_RUN_CONTROL -- requirements
Module: dbg_run_control

---
 rtl/dbg_pkg.sv | 25 ++
 rtl/dbg_run_control_if.sv | 28 ++
 rtl/dbg_hart_ctrl.sv | 99 +++++++++
 rtl/dbg_run_control.sv | 60 ++++++
 tb/tb_dbg_run_control.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Shared encodings for the debug run-control block:
// command opcodes, per-hart FSM states and halt causes.
package dbg_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_HALT   = 2'b01,
        OP_STEP   = 2'b10,
        OP_RESUME = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } hart_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_DEBUGGER = 2'b01,
        CAUSE_BREAK    = 2'b10,
        CAUSE_STEP     = 2'b11
    } halt_cause_e;

endpackage

// File: rtl/dbg_run_control_if.sv
// Debug command handshake: the debugger side drives a command,
// run control answers with cmd_ready.
interface dbg_run_control_if #(
    parameter int NHARTS = 2,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [NHARTS-1:0] cmd_mask;
    logic [STEP_W-1:0] cmd_count;
    logic              cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_mask,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_mask,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/dbg_hart_ctrl.sv
// Per-hart run/halt/step FSM with step counter and a
// registered clock enable that tracks the next state.
module dbg_hart_ctrl
    import dbg_pkg::*;
#(
    parameter int STEP_W = 8
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              sel,
    input  logic [1:0]        op,
    input  logic [STEP_W-1:0] count,
    input  logic              brk,
    output logic              clk_en,
    output logic              halted,
    output logic              in_step,
    output logic [1:0]        cause
);

    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_HALT = ST_HALT;
    localparam logic [1:0] S_STEP = ST_STEP;

    localparam logic [STEP_W-1:0] ONE = 1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        cause_nxt;
    logic [STEP_W-1:0] cnt;
    logic [STEP_W-1:0] cnt_nxt;
    logic [STEP_W-1:0] cnt_load;
    logic              hit;

    assign hit = accept & sel;

    // A count of zero still runs one cycle; the counter holds
    // remaining cycles after the current one, so it never wraps.
    assign cnt_load = (count == '0) ? '0 : count - ONE;

    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        cnt_nxt   = cnt;
        case (state)
            S_RUN: begin
                if (brk) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_BREAK;
                end else if (hit && op == OP_HALT) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_DEBUGGER;
                end
            end
            S_HALT: begin
                if (hit && op == OP_STEP) begin
                    state_nxt = S_STEP;
                    cnt_nxt   = cnt_load;
                end else if (hit && op == OP_RESUME) begin
                    state_nxt = S_RUN;
                    cause_nxt = CAUSE_NONE;
                end
            end
            S_STEP: begin
                if (brk) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_BREAK;
                end else if (cnt == '0) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_STEP;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            default: begin
                state_nxt = S_RUN;
                cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state  <= S_RUN;
            cause  <= CAUSE_NONE;
            cnt    <= '0;
            clk_en <= 1'b1;
        end else begin
            state  <= state_nxt;
            cause  <= cause_nxt;
            cnt    <= cnt_nxt;
            clk_en <= (state_nxt != S_HALT);
        end
    end

    assign halted  = (state == S_HALT);
    assign in_step = (state == S_STEP);

endmodule

// File: rtl/dbg_run_control.sv
// Debug run control: one FSM per hart, shared command port,
// step-complete pulse and halted reductions.
module dbg_run_control
    import dbg_pkg::*;
#(
    parameter int NHARTS = 2,
    parameter int STEP_W = 8
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    dbg_run_control_if.slave      cmd,
    input  logic [NHARTS-1:0]     brk_req,
    output logic [NHARTS-1:0]     clk_en,
    output logic [NHARTS-1:0]     halted,
    output logic [2*NHARTS-1:0]   halt_cause,
    output logic                  step_done,
    output logic                  all_halted,
    output logic                  any_halted
);

    logic [NHARTS-1:0] in_step;
    logic              accept;
    logic              was_step;

    // Commands are held off while any hart is stepping.
    assign cmd.cmd_ready = ~|in_step;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;

    for (genvar i = 0; i < NHARTS; i++) begin : g_hart
        dbg_hart_ctrl #(
            .STEP_W (STEP_W)
        ) u_hart (
            .sys_clk (sys_clk),
            .reset   (reset),
            .accept  (accept),
            .sel     (cmd.cmd_mask[i]),
            .op      (cmd.cmd_op),
            .count   (cmd.cmd_count),
            .brk     (brk_req[i]),
            .clk_en  (clk_en[i]),
            .halted  (halted[i]),
            .in_step (in_step[i]),
            .cause   (halt_cause[2*i +: 2])
        );
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            was_step <= 1'b0;
        end else begin
            was_step <= |in_step;
        end
    end

    // High for the cycle right after the last stepping hart leaves STEP.
    assign step_done  = was_step & ~|in_step;
    assign all_halted = &halted;
    assign any_halted = |halted;

endmodule

// File: tb/tb_dbg_run_control.sv
// Directed bench for dbg_run_control: a driver queues expected outputs
// per cycle, a monitor pops and compares them on the falling edge.
module tb_dbg_run_control;

    localparam int NH = 2;
    localparam int SW = 8;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] HLT = 2'b01;
    localparam logic [1:0] STP = 2'b10;
    localparam logic [1:0] RES = 2'b11;

    typedef struct {
        string      nm;
        logic [1:0] en;
        logic [1:0] hl;
        logic [3:0] cs;
        logic       rdy;
        logic       sd;
    } exp_t;

    logic          sys_clk;
    logic          reset;
    logic [NH-1:0] brk_req;
    logic [NH-1:0] clk_en;
    logic [NH-1:0] halted;
    logic [2*NH-1:0] halt_cause;
    logic          step_done;
    logic          all_halted;
    logic          any_halted;

    int tests;
    int fails;
    exp_t q[$];

    dbg_run_control_if #(.NHARTS(NH), .STEP_W(SW)) cmd ();

    dbg_run_control #(
        .NHARTS (NH),
        .STEP_W (SW)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .cmd        (cmd),
        .brk_req    (brk_req),
        .clk_en     (clk_en),
        .halted     (halted),
        .halt_cause (halt_cause),
        .step_done  (step_done),
        .all_halted (all_halted),
        .any_halted (any_halted)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Inputs apply for this cycle; expected values are the outputs
    // seen during this cycle, before the edge that consumes the inputs.
    task automatic v(
        input string      nm,
        input logic       rst,
        input logic       val,
        input logic [1:0] op,
        input logic [1:0] mask,
        input logic [7:0] cnt,
        input logic [1:0] brk,
        input logic [1:0] en,
        input logic [1:0] hl,
        input logic [3:0] cs,
        input logic       rdy,
        input logic       sd
    );
        exp_t e;
        reset         = rst;
        cmd.cmd_valid = val;
        cmd.cmd_op    = op;
        cmd.cmd_mask  = mask;
        cmd.cmd_count = cnt;
        brk_req       = brk;
        e.nm  = nm;
        e.en  = en;
        e.hl  = hl;
        e.cs  = cs;
        e.rdy = rdy;
        e.sd  = sd;
        q.push_back(e);
        @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic ok;
            e = q.pop_front();
            ok = (clk_en === e.en) && (halted === e.hl) &&
                 (halt_cause === e.cs) && (cmd.cmd_ready === e.rdy) &&
                 (step_done === e.sd) && (any_halted === (|e.hl)) &&
                 (all_halted === (&e.hl));
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL %s: got en=%b hl=%b cs=%b rdy=%b sd=%b any=%b all=%b exp en=%b hl=%b cs=%b rdy=%b sd=%b any=%b all=%b",
                         e.nm, clk_en, halted, halt_cause, cmd.cmd_ready,
                         step_done, any_halted, all_halted, e.en, e.hl, e.cs,
                         e.rdy, e.sd, |e.hl, &e.hl);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = NOP;
        cmd.cmd_mask  = '0;
        cmd.cmd_count = '0;
        brk_req       = '0;
        @(posedge sys_clk);
        #1;
        //  name            rst val op   mask cnt  brk    en     hl     cs       rdy sd
        v("reset",          0, 0, NOP, 2'b00, 0, 2'b00, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("halt_all",       0, 1, HLT, 2'b11, 0, 2'b00, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("halted_all",     0, 0, NOP, 2'b00, 0, 2'b00, 2'b00, 2'b11, 4'b0101, 1, 0);
        v("step3_issue",    0, 1, STP, 2'b01, 3, 2'b00, 2'b00, 2'b11, 4'b0101, 1, 0);
        v("step3_c1",       0, 1, RES, 2'b10, 0, 2'b00, 2'b01, 2'b10, 4'b0101, 0, 0);
        v("step3_c2",       0, 1, RES, 2'b10, 0, 2'b00, 2'b01, 2'b10, 4'b0101, 0, 0);
        v("step3_c3",       0, 1, RES, 2'b10, 0, 2'b00, 2'b01, 2'b10, 4'b0101, 0, 0);
        v("step3_done",     0, 0, NOP, 2'b00, 0, 2'b00, 2'b00, 2'b11, 4'b0111, 1, 1);
        v("step3_after",    0, 0, NOP, 2'b00, 0, 2'b00, 2'b00, 2'b11, 4'b0111, 1, 0);
        v("step5_issue",    0, 1, STP, 2'b01, 5, 2'b00, 2'b00, 2'b11, 4'b0111, 1, 0);
        v("step5_c1",       0, 0, NOP, 2'b00, 0, 2'b00, 2'b01, 2'b10, 4'b0111, 0, 0);
        v("step5_c2_brk",   0, 0, NOP, 2'b00, 0, 2'b01, 2'b01, 2'b10, 4'b0111, 0, 0);
        v("step5_brk_done", 0, 0, NOP, 2'b00, 0, 2'b00, 2'b00, 2'b11, 4'b0110, 1, 1);
        v("brk_in_halt",    0, 0, NOP, 2'b00, 0, 2'b11, 2'b00, 2'b11, 4'b0110, 1, 0);
        v("brk_ignored",    0, 0, NOP, 2'b00, 0, 2'b00, 2'b00, 2'b11, 4'b0110, 1, 0);
        v("resume_all",     0, 1, RES, 2'b11, 0, 2'b00, 2'b00, 2'b11, 4'b0110, 1, 0);
        v("brk_vs_halt",    0, 1, HLT, 2'b10, 0, 2'b10, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("h1_brk",         0, 0, NOP, 2'b00, 0, 2'b00, 2'b01, 2'b10, 4'b1000, 1, 0);
        v("resume_h1",      0, 1, RES, 2'b10, 0, 2'b00, 2'b01, 2'b10, 4'b1000, 1, 0);
        v("h1_resumed",     0, 1, NOP, 2'b11, 0, 2'b00, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("after_nop",      0, 1, HLT, 2'b00, 0, 2'b00, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("after_mask0",    0, 1, RES, 2'b11, 0, 2'b00, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("after_res_run",  0, 1, STP, 2'b11, 4, 2'b00, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("halt_h0",        0, 1, HLT, 2'b01, 0, 2'b00, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("h0_halted",      0, 1, HLT, 2'b01, 0, 2'b00, 2'b10, 2'b01, 4'b0001, 1, 0);
        v("halt_on_halt",   0, 0, NOP, 2'b00, 0, 2'b00, 2'b10, 2'b01, 4'b0001, 1, 0);
        v("step0_issue",    0, 1, STP, 2'b01, 0, 2'b00, 2'b10, 2'b01, 4'b0001, 1, 0);
        v("step0_c1",       0, 0, NOP, 2'b00, 0, 2'b00, 2'b11, 2'b00, 4'b0001, 0, 0);
        v("step0_done",     0, 0, NOP, 2'b00, 0, 2'b00, 2'b10, 2'b01, 4'b0011, 1, 1);
        v("step10_issue",   0, 1, STP, 2'b01, 10, 2'b00, 2'b10, 2'b01, 4'b0011, 1, 0);
        v("step10_c1",      0, 0, NOP, 2'b00, 0, 2'b00, 2'b11, 2'b00, 4'b0011, 0, 0);
        v("step10_rst",     1, 1, HLT, 2'b11, 0, 2'b11, 2'b11, 2'b00, 4'b0011, 0, 0);
        v("after_rst",      0, 0, NOP, 2'b00, 0, 2'b00, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("after_rst2",     0, 1, HLT, 2'b11, 0, 2'b00, 2'b11, 2'b00, 4'b0000, 1, 0);
        v("step2_issue",    0, 1, STP, 2'b11, 2, 2'b00, 2'b00, 2'b11, 4'b0101, 1, 0);
        v("step2_c1_brk0",  0, 0, NOP, 2'b00, 0, 2'b01, 2'b11, 2'b00, 4'b0101, 0, 0);
        v("step2_c2",       0, 0, NOP, 2'b00, 0, 2'b00, 2'b10, 2'b01, 4'b0110, 0, 0);
        v("step2_done",     0, 0, NOP, 2'b00, 0, 2'b00, 2'b00, 2'b11, 4'b1110, 1, 1);
        v("stepmax_issue",  0, 1, STP, 2'b10, 255, 2'b00, 2'b00, 2'b11, 4'b1110, 1, 0);
        for (int i = 0; i < 255; i++) begin
            v("stepmax_run", 0, 0, NOP, 2'b00, 0, 2'b00, 2'b10, 2'b01, 4'b1110, 0, 0);
        end
        v("stepmax_done",   0, 0, NOP, 2'b00, 0, 2'b00, 2'b00, 2'b11, 4'b1110, 1, 1);
        v("stepmax_after",  0, 0, NOP, 2'b00, 0, 2'b00, 2'b00, 2'b11, 4'b1110, 1, 0);
        @(negedge sys_clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
